// File: rtl/frogger_pkg.sv
// rtl/frogger_pkg.sv - shared direction/state types and keycode constants for the frog input path
package frogger_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2,
        RPT_HOLD   = 2'd3
    } rpt_state_t;

    localparam logic [7:0] KEY_UP        = 8'h52;
    localparam logic [7:0] KEY_DOWN      = 8'h51;
    localparam logic [7:0] KEY_LEFT      = 8'h50;
    localparam logic [7:0] KEY_RIGHT     = 8'h4F;
    localparam logic [7:0] KEY_FROG_BASE = 8'h59;

    // Bit order matches held_dir/last_dir: {right, left, down, up}.
    function automatic logic [3:0] dir_onehot(input dir_t d);
        return 4'b0001 << d;
    endfunction

endpackage

// File: rtl/frog_input_ctrl_if.sv
// rtl/frog_input_ctrl_if.sv - keycode/frame inputs and decoded move/select outputs of the frog input decoder
interface frog_input_ctrl_if #(
    parameter int NUM_FROGS = 3,
    parameter int KEYCODE_W = 16
) ();

    logic [KEYCODE_W-1:0]  keycode;
    logic                  vs;
    logic [NUM_FROGS-1:0]  frog_sel;
    logic                  sel_valid;
    logic                  move_pulse;
    frogger_pkg::dir_t     move_dir;
    logic [3:0]            held_dir;
    logic [3:0]            last_dir;

    modport master (
        output keycode, vs,
        input  frog_sel, sel_valid, move_pulse, move_dir, held_dir, last_dir
    );

    modport slave (
        input  keycode, vs,
        output frog_sel, sel_valid, move_pulse, move_dir, held_dir, last_dir
    );

endinterface

// File: rtl/key_repeat_timer.sv
// rtl/key_repeat_timer.sv - press/auto-repeat FSM clocked by VGA frame ticks; fires one-cycle move pulses
module key_repeat_timer
    import frogger_pkg::*;
#(
    parameter int REPEAT_DELAY = 30,
    parameter int REPEAT_RATE  = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic vs_i,
    input  logic press_i,
    input  logic change_i,
    input  logic release_i,
    input  logic fire_en_i,
    output logic fire_o
);

    localparam logic [7:0]  DELAY_LD = 8'(REPEAT_DELAY);
    localparam logic [7:0]  RATE_LD  = 8'(REPEAT_RATE);
    // A zero delay means a held key never repeats, so a new press parks in HOLD.
    localparam rpt_state_t  ARMED    = rpt_state_t'((REPEAT_DELAY == 0) ? RPT_HOLD : RPT_DELAY);

    rpt_state_t  state_q;
    logic [7:0]  cnt_q;
    logic        vs_q;
    logic        fire_q;
    logic        tick;
    logic [7:0]  cnt_dec;

    assign tick    = vs_i & ~vs_q;
    assign cnt_dec = (cnt_q == 8'd0) ? 8'd0 : cnt_q - 8'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RPT_IDLE;
            cnt_q   <= 8'd0;
            vs_q    <= 1'b0;
            fire_q  <= 1'b0;
        end else begin
            vs_q   <= vs_i;
            fire_q <= 1'b0;
            case (state_q)
                RPT_IDLE: begin
                    if (press_i) begin
                        fire_q  <= fire_en_i;
                        cnt_q   <= DELAY_LD;
                        state_q <= ARMED;
                    end
                end
                default: begin
                    // Release beats change, and a change swallows a coincident tick.
                    if (release_i) begin
                        state_q <= RPT_IDLE;
                    end else if (change_i) begin
                        fire_q  <= fire_en_i;
                        cnt_q   <= DELAY_LD;
                        state_q <= ARMED;
                    end else if (tick && (state_q != RPT_HOLD)) begin
                        if (cnt_dec == 8'd0) begin
                            fire_q  <= fire_en_i;
                            cnt_q   <= RATE_LD;
                            state_q <= RPT_REPEAT;
                        end else begin
                            cnt_q <= cnt_dec;
                        end
                    end
                end
            endcase
        end
    end

    assign fire_o = fire_q;

endmodule

// File: rtl/frog_input_ctrl.sv
// rtl/frog_input_ctrl.sv - decodes keypad keycodes into a latched frog selection and auto-repeating move pulses
module frog_input_ctrl
    import frogger_pkg::*;
#(
    parameter int                   NUM_FROGS    = 3,
    parameter int                   KEYCODE_W    = 16,
    parameter logic [KEYCODE_W-1:0] SEL_KEY_BASE = KEYCODE_W'(KEY_FROG_BASE),
    parameter int                   REPEAT_DELAY = 30,
    parameter int                   REPEAT_RATE  = 8
) (
    input  logic               Clk,
    input  logic               Reset,
    frog_input_ctrl_if.slave   bus
);

    logic [KEYCODE_W-1:0]  k_q;
    logic [NUM_FROGS-1:0]  frog_sel_q;
    logic [NUM_FROGS-1:0]  sel_onehot;
    logic                  sel_hit;
    logic                  sel_valid;
    logic                  arrow;
    logic                  change;
    logic                  fire;
    dir_t                  dir_k;
    dir_t                  move_dir_q;
    logic [3:0]            dir_oh;
    logic [3:0]            held_dir_q;
    logic [3:0]            last_dir_q;

    always_comb begin
        arrow = 1'b1;
        dir_k = DIR_UP;
        if (k_q == KEYCODE_W'(KEY_UP)) begin
            dir_k = DIR_UP;
        end else if (k_q == KEYCODE_W'(KEY_DOWN)) begin
            dir_k = DIR_DOWN;
        end else if (k_q == KEYCODE_W'(KEY_LEFT)) begin
            dir_k = DIR_LEFT;
        end else if (k_q == KEYCODE_W'(KEY_RIGHT)) begin
            dir_k = DIR_RIGHT;
        end else begin
            arrow = 1'b0;
        end
    end

    always_comb begin
        sel_hit    = 1'b0;
        sel_onehot = '0;
        for (int i = 0; i < NUM_FROGS; i++) begin
            if (k_q == SEL_KEY_BASE + KEYCODE_W'(i)) begin
                sel_hit       = 1'b1;
                sel_onehot[i] = 1'b1;
            end
        end
    end

    assign sel_valid = |frog_sel_q;
    assign dir_oh    = dir_onehot(dir_k);
    // held_dir_q is zero exactly when the timer is idle, so this also covers a fresh press.
    assign change    = arrow && (held_dir_q != dir_oh);

    key_repeat_timer #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_timer (
        .clk       (Clk),
        .rst       (Reset),
        .vs_i      (bus.vs),
        .press_i   (arrow),
        .change_i  (change),
        .release_i (!arrow),
        .fire_en_i (sel_valid),
        .fire_o    (fire)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            k_q        <= '0;
            frog_sel_q <= '0;
            move_dir_q <= DIR_UP;
            held_dir_q <= 4'd0;
            last_dir_q <= 4'd0;
        end else begin
            k_q        <= bus.keycode;
            held_dir_q <= arrow ? dir_oh : 4'd0;
            if (sel_hit) begin
                frog_sel_q <= sel_onehot;
            end
            if (change) begin
                last_dir_q <= dir_oh;
                if (sel_valid) begin
                    move_dir_q <= dir_k;
                end
            end
        end
    end

    assign bus.frog_sel   = frog_sel_q;
    assign bus.sel_valid  = sel_valid;
    assign bus.move_pulse = fire;
    assign bus.move_dir   = move_dir_q;
    assign bus.held_dir   = held_dir_q;
    assign bus.last_dir   = last_dir_q;

endmodule

// File: tb/tb_frog_input_ctrl.sv
// tb/tb_frog_input_ctrl.sv - bench for frog_input_ctrl with default and zero repeat-delay instances
module tb_frog_input_ctrl;

    localparam int RATE = 8;
    localparam int SEL_BASE = 'h59;
    localparam int NFROG = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    frog_input_ctrl_if #(.NUM_FROGS(NFROG), .KEYCODE_W(16)) bus_a ();
    frog_input_ctrl_if #(.NUM_FROGS(NFROG), .KEYCODE_W(16)) bus_b ();

    frog_input_ctrl #(.REPEAT_DELAY(30), .REPEAT_RATE(RATE)) dut_a (
        .Clk(clk), .Reset(rst), .bus(bus_a)
    );
    frog_input_ctrl #(.REPEAT_DELAY(0), .REPEAT_RATE(RATE)) dut_b (
        .Clk(clk), .Reset(rst), .bus(bus_b)
    );

    always #5 clk = ~clk;

    // Reference model: hold time measured in frame ticks since the current direction began.
    int dly[2] = '{30, 0};
    int m_k, m_vs_prev, m_sel;
    int m_held[2], m_ticks[2], m_last[2], m_dir[2], m_pulse[2];
    int n_pulse[2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int arrow_of(input int k);
        case (k)
            'h52: return 0;
            'h51: return 1;
            'h50: return 2;
            'h4F: return 3;
            default: return -1;
        endcase
    endfunction

    function automatic int oh(input int d);
        return (d < 0) ? 0 : (1 << d);
    endfunction

    task automatic model_reset();
        m_k = 0; m_vs_prev = 0; m_sel = 0;
        for (int i = 0; i < 2; i++) begin
            m_held[i] = -1; m_ticks[i] = 0; m_last[i] = -1; m_dir[i] = 0; m_pulse[i] = 0;
        end
    endtask

    task automatic model_edge(input int kc, input int v);
        int  a;
        bit  tick, selv, fire;
        a    = arrow_of(m_k);
        tick = (v != 0) && (m_vs_prev == 0);
        selv = (m_sel != 0);
        for (int i = 0; i < 2; i++) begin
            fire = 1'b0;
            m_pulse[i] = 0;
            if (a < 0) begin
                m_held[i] = -1;
            end else if (m_held[i] != a) begin
                m_held[i] = a; m_ticks[i] = 0; m_last[i] = a; fire = 1'b1;
            end else if (tick && dly[i] > 0) begin
                m_ticks[i]++;
                if (m_ticks[i] == dly[i] || (m_ticks[i] > dly[i] && (m_ticks[i] - dly[i]) % RATE == 0))
                    fire = 1'b1;
            end
            if (fire && selv) begin
                m_pulse[i] = 1; m_dir[i] = a;
            end
        end
        if (m_k >= SEL_BASE && m_k < SEL_BASE + NFROG) m_sel = 1 << (m_k - SEL_BASE);
        m_k = kc; m_vs_prev = v;
    endtask

    task automatic check_outputs();
        chk("a.frog_sel",   bus_a.frog_sel,   m_sel);
        chk("a.sel_valid",  bus_a.sel_valid,  (m_sel != 0));
        chk("a.move_pulse", bus_a.move_pulse, m_pulse[0]);
        chk("a.move_dir",   bus_a.move_dir,   m_dir[0]);
        chk("a.held_dir",   bus_a.held_dir,   oh(m_held[0]));
        chk("a.last_dir",   bus_a.last_dir,   oh(m_last[0]));
        chk("b.frog_sel",   bus_b.frog_sel,   m_sel);
        chk("b.sel_valid",  bus_b.sel_valid,  (m_sel != 0));
        chk("b.move_pulse", bus_b.move_pulse, m_pulse[1]);
        chk("b.move_dir",   bus_b.move_dir,   m_dir[1]);
        chk("b.held_dir",   bus_b.held_dir,   oh(m_held[1]));
        chk("b.last_dir",   bus_b.last_dir,   oh(m_last[1]));
        if (bus_a.move_pulse === 1'b1) n_pulse[0]++;
        if (bus_b.move_pulse === 1'b1) n_pulse[1]++;
    endtask

    task automatic step(input int kc, input int v);
        bus_a.keycode = 16'(kc); bus_b.keycode = 16'(kc);
        bus_a.vs = (v != 0);     bus_b.vs = (v != 0);
        @(posedge clk);
        model_edge(kc, v);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic frames(input int kc, input int n);
        for (int f = 0; f < n; f++) begin
            step(kc, 1); step(kc, 0); step(kc, 0); step(kc, 0);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        chk("rst.a.frog_sel", bus_a.frog_sel, 0);
        chk("rst.a.sel_valid", bus_a.sel_valid, 0);
        chk("rst.a.move_pulse", bus_a.move_pulse, 0);
        chk("rst.a.move_dir", bus_a.move_dir, 0);
        chk("rst.a.held_dir", bus_a.held_dir, 0);
        chk("rst.a.last_dir", bus_a.last_dir, 0);
        chk("rst.b.move_pulse", bus_b.move_pulse, 0);
        chk("rst.b.held_dir", bus_b.held_dir, 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic clear_counts();
        n_pulse[0] = 0; n_pulse[1] = 0;
    endtask

    int keys[12] = '{0, 'h52, 'h51, 'h50, 'h4F, 'h59, 'h5A, 'h5B, 'h5C, 'h58, 'h0152, 0};

    initial begin
        bus_a.keycode = '0; bus_b.keycode = '0;
        bus_a.vs = 1'b0;    bus_b.vs = 1'b0;
        clear_counts();
        @(negedge clk);
        apply_reset();

        // Selection latches and holds through key release
        step('h5A, 0); step('h5A, 0);
        chk("sel_5a", bus_a.frog_sel, 3'b010);
        step(0, 0); step(0, 0); step(0, 0);
        chk("sel_hold", bus_a.frog_sel, 3'b010);

        // Arrow with no frog selected: direction tracked, no pulses
        apply_reset();
        clear_counts();
        step('h52, 0); step('h52, 0);
        frames('h52, 40);
        chk("nosel.pulses", n_pulse[0], 0);
        chk("nosel.last_dir", bus_a.last_dir, 4'b0001);
        chk("nosel.held_dir", bus_a.held_dir, 4'b0001);
        step(0, 0); step(0, 0);

        // Default repeat timing on a 60-frame hold
        step('h59, 0); step('h59, 0);
        chk("sel_59", bus_a.frog_sel, 3'b001);
        clear_counts();
        step('h50, 0); step('h50, 0);
        chk("left.first_pulse", bus_a.move_pulse, 1);
        chk("left.move_dir", bus_a.move_dir, 2);
        frames('h50, 29);
        chk("left.before_30", n_pulse[0], 1);
        frames('h50, 1);
        chk("left.at_30", n_pulse[0], 2);
        frames('h50, 30);
        chk("left.total_a", n_pulse[0], 5);
        chk("left.total_b", n_pulse[1], 1);
        step(0, 0); step(0, 0);

        // Direction change restarts the delay
        step('h51, 0); step('h51, 0);
        frames('h51, 10);
        clear_counts();
        step('h4F, 0); step('h4F, 0);
        chk("chg.pulse", bus_a.move_pulse, 1);
        chk("chg.move_dir", bus_a.move_dir, 3);
        frames('h4F, 29);
        chk("chg.before_30", n_pulse[0], 1);
        frames('h4F, 1);
        chk("chg.at_30", n_pulse[0], 2);
        step(0, 0); step(0, 0);

        // Long hold: zero-delay instance fires once only
        clear_counts();
        step('h52, 0); step('h52, 0);
        frames('h52, 100);
        chk("hold100.b", n_pulse[1], 1);
        chk("hold100.a", n_pulse[0], 10);
        step(0, 0); step(0, 0);

        // Reset mid-repeat with the arrow still on the bus
        step('h50, 0); step('h50, 0);
        frames('h50, 40);
        apply_reset();
        step('h50, 0); step('h50, 0);
        chk("rearm.held_dir", bus_a.held_dir, 4'b0100);
        chk("rearm.last_dir", bus_a.last_dir, 4'b0100);
        chk("rearm.frog_sel", bus_a.frog_sel, 0);
        step(0, 0);

        // Randomized key segments against the model
        for (int s = 0; s < 60; s++) begin
            int kc, len;
            kc  = keys[$urandom_range(0, 11)];
            len = $urandom_range(1, 150);
            if ($urandom_range(0, 39) == 0) apply_reset();
            for (int c = 0; c < len; c++) step(kc, $urandom_range(0, 1));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
